decoder_onehot_scan: RTL
========================

# decoder_onehot_scan

Parametrised, registered binary-to-one-hot decoder with 2^SEL_W outputs. It is the successor to the fixed combinational 3-to-8 decoder. It adds an enable, registered outputs, selectable output polarity, and an autonomous scan mode. In scan mode a walking one steps through all outputs with a programmable dwell time, for use as a display digit or row multiplexer. It sits between control logic and multiplexed output drivers (LED/7-segment digit selects, keypad row drive).

## Interface
Parameters:
- SEL_W, 3, select width; NOUT = 2^SEL_W outputs; legal range 1..6
- DWELL_W, 4, width of dwell-count input
- ACTIVE_LOW, 0, 1 = dout active-low (inactive level all ones)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  block enable; 0 forces IDLE
- mode  input  1  0 = DECODE, 1 = SCAN
- sel  input  SEL_W  binary select, used in DECODE
- sel_valid  input  1  capture strobe for sel (DECODE only)
- dwell  input  DWELL_W  extra cycles each output stays active in SCAN
- dout  output  NOUT  registered one-hot output (polarity per ACTIVE_LOW)
- cur_idx  output  SEL_W  index of the currently active output
- wrap  output  1  one-cycle pulse when SCAN returns to index 0

## Operation
- Reset (rst_n=0, immediate, asynchronous):
  - state=IDLE, dout=inactive (all 0, or all 1 if ACTIVE_LOW), cur_idx=0, wrap=0, dwell counter=0.
- States: IDLE, DECODE, SCAN. Next-state rules are evaluated every cycle:
  - en=0 → IDLE from any state.
  - en=1, mode=0 → DECODE.
  - en=1, mode=1 → SCAN.
- IDLE: dout inactive, cur_idx holds, wrap=0.
- DECODE entry (from IDLE or SCAN):
  - dout goes inactive unless sel_valid=1 in the entry cycle; in that case dout=onehot(sel) is captured directly.
- DECODE:
  - On sel_valid=1: dout←onehot(sel), cur_idx←sel.
  - Without sel_valid: dout and cur_idx hold; sel changes are ignored.
  - wrap=0.
- SCAN entry (from IDLE or DECODE):
  - cur_idx←0, dout←onehot(0), dwell counter←0, wrap=0.
- SCAN:
  - The dwell counter increments each cycle.
  - When counter ≥ dwell (live value): counter←0 and cur_idx←cur_idx+1 modulo NOUT; dout follows.
  - Each output is therefore active dwell+1 cycles; dwell=0 advances every cycle.
  - The ≥ compare makes a dwell decrease below the current count advance on the next cycle, with no long wrap of the counter.
  - sel and sel_valid are ignored.
- wrap: asserted for exactly one cycle, coincident with cur_idx changing from NOUT-1 to 0. It is not asserted on SCAN entry.
- Polarity: ACTIVE_LOW inverts dout only. cur_idx and wrap are always active-high.
- Exactly one dout bit is active in DECODE (after capture) and in SCAN; none in IDLE.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Decode latency: sel_valid sampled at edge N → dout valid after edge N.
- Enable latency: en sampled at edge N → state/dout change after edge N.
  - en=0 blanks dout one cycle later.
  - First scan output appears one cycle after en/mode sampled.
- Scan period = NOUT × (dwell+1) cycles.
- mode toggling with en=1 restarts the target state's entry rule on the next edge. A SCAN→SCAN hold never restarts.
- rst_n deassertion is not synchronised internally; the top level provides a synchronised release.

## Test plan
- Reset: rst_n=0 mid-SCAN at cur_idx=4 → without waiting for a clock, dout=8'h00, cur_idx=0, wrap=0. After release with en=0, dout stays 8'h00.
- Decode (SEL_W=3): en=1, mode=0, sel=5, sel_valid pulse → next cycle dout=8'h20, cur_idx=5. Then sel=2 with sel_valid=0 → dout holds 8'h20. Then sel=2 with sel_valid=1 → dout=8'h04.
- Scan dwell=2: en=1, mode=1 → dout 8'h01 for 3 cycles, 8'h02 for 3, …, 8'h80 for 3, then 8'h01 with wrap=1 for that single cycle. Period 24 cycles; no wrap at entry.
- Scan boundaries:
  - dwell=0 → dout shifts every cycle, wrap every 8 cycles.
  - dwell=7 with counter=5, then dwell set to 1 → advance on next edge.
  - Switch mode 1→0 with sel_valid=1, sel=6 → dout=8'h40 next cycle.
  - Switch mode 0→1 → dout=8'h01 next cycle.
- Enable: en=0 at cur_idx=3 in SCAN → dout=8'h00 next cycle. Re-enable → restart at 8'h01, cur_idx=0.
- Polarity/width: ACTIVE_LOW=1, SEL_W=2 → reset dout=4'hF. Decode sel=2 → dout=4'hB. Scan dwell=0 → 4'hE, 4'hD, 4'hB, 4'h7 then wrap.

Source files
------------

// File: rtl/decoder_onehot_scan.sv
// Registered binary-to-one-hot decoder with enable, selectable polarity and an
// autonomous walking-one scan mode with programmable dwell.
//
// state  | meaning
// IDLE   | disabled, dout inactive, cur_idx holds
// DECODE | dout = onehot(sel) captured on sel_valid
// SCAN   | walking one, each output held dwell+1 cycles
module decoder_onehot_scan #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   dout,
    output logic [SEL_W-1:0]        cur_idx,
    output logic                    wrap
);
    localparam int   NOUT = 1 << SEL_W;
    localparam logic POL  = (ACTIVE_LOW != 0);
    localparam logic [NOUT-1:0] ONE = {{(NOUT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_SCAN} state_t;

    state_t               state, state_nxt;
    logic [NOUT-1:0]      onehot_q, onehot_nxt;
    logic [SEL_W-1:0]     idx_nxt;
    logic [DWELL_W-1:0]   cnt_q, cnt_nxt;
    logic                 wrap_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            onehot_q <= '0;
            cur_idx  <= '0;
            cnt_q    <= '0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_nxt;
            onehot_q <= onehot_nxt;
            cur_idx  <= idx_nxt;
            cnt_q    <= cnt_nxt;
            wrap     <= wrap_nxt;
        end
    end

    // Outputs are computed from the next state so entry rules land on the same edge.
    always_comb begin
        state_nxt  = !en ? ST_IDLE : (mode ? ST_SCAN : ST_DECODE);
        onehot_nxt = onehot_q;
        idx_nxt    = cur_idx;
        cnt_nxt    = cnt_q;
        wrap_nxt   = 1'b0;
        case (state_nxt)
            ST_IDLE: begin
                onehot_nxt = '0;
                cnt_nxt    = '0;
            end
            ST_DECODE: begin
                cnt_nxt = '0;
                if (sel_valid) begin
                    onehot_nxt = ONE << sel;
                    idx_nxt    = sel;
                end else if (state != ST_DECODE) begin
                    onehot_nxt = '0;
                end
            end
            ST_SCAN: begin
                if (state != ST_SCAN) begin
                    onehot_nxt = ONE;
                    idx_nxt    = '0;
                    cnt_nxt    = '0;
                end else if (cnt_q >= dwell) begin
                    // >= so a lowered dwell advances immediately instead of wrapping the counter
                    cnt_nxt    = '0;
                    idx_nxt    = cur_idx + SEL_W'(1);
                    onehot_nxt = ONE << idx_nxt;
                    wrap_nxt   = (cur_idx == SEL_W'(NOUT - 1));
                end else begin
                    cnt_nxt = cnt_q + DWELL_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign dout = onehot_q ^ {NOUT{POL}};

endmodule
